// File: rtl/hssl_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hssl_seq_pkg
// Brief   : Shared types and constants for the HSSL link bring-up sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package hssl_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RST_ALL   = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_WAIT_DP   = 3'd3,
        ST_ALIGN     = 3'd4,
        ST_UP        = 3'd5,
        ST_FAIL      = 3'd6
    } state_t;

    localparam logic [15:0] c_DROP_SAT = 16'hFFFF;

    // Timer only needs to reach max(TIMEOUT, RESET_CYCLES) - 1.
    function automatic int timer_width(input int timeout, input int reset_cycles);
        int m;
        m = (timeout > reset_cycles) ? timeout : reset_cycles;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    localparam int c_TIMER_W = timer_width(65536, 8);

endpackage
`default_nettype wire

// File: rtl/hssl_seq_timer.sv
`default_nettype none
// ============================================================================
// Module  : hssl_seq_timer
// Brief   : Clearable saturating up-counter with terminal-count compare.
// Revision: 1.0 - initial release
// ============================================================================
module hssl_seq_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_terminal,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (r_count != {WIDTH{1'b1}}) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == i_terminal);

endmodule
`default_nettype wire

// File: rtl/hssl_link_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : hssl_link_sequencer
// Brief   : GTH reset sequencing and HSSL link bring-up/recovery controller.
// Revision: 1.0 - initial release
// ============================================================================
module hssl_link_sequencer
    import hssl_seq_pkg::*;
#(
    parameter int RESET_CYCLES = 8,
    parameter int LOCK_FILTER  = 4,
    parameter int TIMEOUT      = 65536,
    parameter int MAX_RETRIES  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        pll_lock,
    input  logic        tx_reset_done,
    input  logic        rx_reset_done,
    input  logic        rx_aligned,
    input  logic        hssl_handshake,
    output logic        gth_reset_all,
    output logic        gth_tx_reset,
    output logic        gth_rx_reset,
    output logic        hssl_enable,
    output logic        link_up,
    output logic        fail,
    output logic [2:0]  state,
    output logic [3:0]  retry_cnt,
    output logic [15:0] drop_cnt
);

    localparam int c_TW = timer_width(TIMEOUT, RESET_CYCLES);
    localparam int c_LW = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
    localparam logic [c_TW-1:0] c_RST_TERM = c_TW'(RESET_CYCLES - 1);
    localparam logic [c_TW-1:0] c_TO_TERM  = c_TW'(TIMEOUT - 1);
    localparam logic [c_LW-1:0] c_LF_TERM  = c_LW'(LOCK_FILTER - 1);
    localparam logic [3:0]      c_MAX_RTY  = 4'(MAX_RETRIES);

    state_t            r_state;
    state_t            w_next;
    logic              r_start_d;
    logic [c_LW-1:0]   r_lock_cnt;
    logic [3:0]        r_retry_cnt;
    logic [3:0]        w_retry_nxt;
    logic [15:0]       r_drop_cnt;
    logic [15:0]       w_drop_nxt;
    logic              r_rst_all, r_tx_rst, r_rx_rst, r_enable, r_link_up, r_fail;
    logic              w_rst_all, w_tx_rst, w_rx_rst, w_enable, w_link_up, w_fail;
    logic              w_start_edge;
    logic              w_lock_ok;
    logic              w_timeout;
    logic              w_tc;
    logic [c_TW-1:0]   w_terminal;

    assign w_start_edge = start & ~r_start_d;
    assign w_lock_ok    = pll_lock && (r_lock_cnt == c_LF_TERM);
    assign w_terminal   = (r_state == ST_RST_ALL) ? c_RST_TERM : c_TO_TERM;

    hssl_seq_timer #(
        .WIDTH (c_TW)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_next != r_state),
        .i_terminal (w_terminal),
        .o_tc       (w_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_start_d   <= 1'b0;
            r_lock_cnt  <= '0;
            r_retry_cnt <= '0;
            r_drop_cnt  <= '0;
            r_rst_all   <= 1'b1;
            r_tx_rst    <= 1'b1;
            r_rx_rst    <= 1'b1;
            r_enable    <= 1'b0;
            r_link_up   <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_start_d   <= start;
            r_retry_cnt <= w_retry_nxt;
            r_drop_cnt  <= w_drop_nxt;
            r_rst_all   <= w_rst_all;
            r_tx_rst    <= w_tx_rst;
            r_rx_rst    <= w_rx_rst;
            r_enable    <= w_enable;
            r_link_up   <= w_link_up;
            r_fail      <= w_fail;
            // Counts consecutive high samples of pll_lock while in WAIT_LOCK.
            if (r_state == ST_WAIT_LOCK && pll_lock) begin
                if (r_lock_cnt != c_LF_TERM) begin
                    r_lock_cnt <= r_lock_cnt + 1'b1;
                end
            end else begin
                r_lock_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_retry_nxt = r_retry_cnt;
        w_drop_nxt  = r_drop_cnt;
        w_timeout   = 1'b0;
        if (stop) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_FAIL: begin
                    if (w_start_edge) begin
                        w_next      = ST_RST_ALL;
                        w_retry_nxt = '0;
                    end
                end
                ST_RST_ALL: begin
                    if (w_tc) w_next = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (w_lock_ok)  w_next    = ST_WAIT_DP;
                    else if (w_tc)  w_timeout = 1'b1;
                end
                ST_WAIT_DP: begin
                    if (tx_reset_done && rx_reset_done) w_next    = ST_ALIGN;
                    else if (w_tc)                      w_timeout = 1'b1;
                end
                ST_ALIGN: begin
                    if (rx_aligned && hssl_handshake) w_next    = ST_UP;
                    else if (w_tc)                    w_timeout = 1'b1;
                end
                ST_UP: begin
                    if (!pll_lock || !rx_aligned) begin
                        w_next      = ST_RST_ALL;
                        w_retry_nxt = '0;
                        if (r_drop_cnt != c_DROP_SAT) w_drop_nxt = r_drop_cnt + 16'd1;
                    end
                end
                default: w_next = ST_IDLE;
            endcase
            if (w_timeout) begin
                if (r_retry_cnt == c_MAX_RTY) begin
                    w_next = ST_FAIL;
                end else begin
                    w_next      = ST_RST_ALL;
                    w_retry_nxt = r_retry_cnt + 4'd1;
                end
            end
        end
    end

    // Outputs decode the next state so they land with the state change.
    always_comb begin
        w_rst_all = 1'b1;
        w_tx_rst  = 1'b1;
        w_rx_rst  = 1'b1;
        w_enable  = 1'b0;
        w_link_up = 1'b0;
        w_fail    = 1'b0;
        case (w_next)
            ST_WAIT_LOCK: w_rst_all = 1'b0;
            ST_WAIT_DP: begin
                w_rst_all = 1'b0;
                w_tx_rst  = 1'b0;
                w_rx_rst  = 1'b0;
            end
            ST_ALIGN, ST_UP: begin
                w_rst_all = 1'b0;
                w_tx_rst  = 1'b0;
                w_rx_rst  = 1'b0;
                w_enable  = 1'b1;
                w_link_up = (w_next == ST_UP);
            end
            ST_FAIL: w_fail = 1'b1;
            default: ;
        endcase
    end

    assign gth_reset_all = r_rst_all;
    assign gth_tx_reset  = r_tx_rst;
    assign gth_rx_reset  = r_rx_rst;
    assign hssl_enable   = r_enable;
    assign link_up       = r_link_up;
    assign fail          = r_fail;
    assign state         = r_state;
    assign retry_cnt     = r_retry_cnt;
    assign drop_cnt      = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hssl_link_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_hssl_link_sequencer
// Brief   : Scoreboard bench for the HSSL link sequencer state flow and timing.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hssl_link_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, start, stop, pll_lock, tx_reset_done, rx_reset_done;
    logic        rx_aligned, hssl_handshake;
    logic        gth_reset_all, gth_tx_reset, gth_rx_reset, hssl_enable, link_up, fail;
    logic [2:0]  state;
    logic [3:0]  retry_cnt;
    logic [15:0] drop_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [2:0]  sb_q[$];
    logic [2:0]  mon_prev = 3'd0;
    int          n;

    always #5 clk = ~clk;

    hssl_link_sequencer #(
        .RESET_CYCLES (8),
        .LOCK_FILTER  (4),
        .TIMEOUT      (64),
        .MAX_RETRIES  (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .stop           (stop),
        .pll_lock       (pll_lock),
        .tx_reset_done  (tx_reset_done),
        .rx_reset_done  (rx_reset_done),
        .rx_aligned     (rx_aligned),
        .hssl_handshake (hssl_handshake),
        .gth_reset_all  (gth_reset_all),
        .gth_tx_reset   (gth_tx_reset),
        .gth_rx_reset   (gth_rx_reset),
        .hssl_enable    (hssl_enable),
        .link_up        (link_up),
        .fail           (fail),
        .state          (state),
        .retry_cnt      (retry_cnt),
        .drop_cnt       (drop_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // {reset_all, tx_reset, rx_reset, enable, link_up, fail} per state
    function automatic logic [5:0] exp_outs(input logic [2:0] st);
        case (st)
            3'd2:    return 6'b011000;
            3'd3:    return 6'b000000;
            3'd4:    return 6'b000100;
            3'd5:    return 6'b000110;
            3'd6:    return 6'b111001;
            default: return 6'b111000;
        endcase
    endfunction

    function automatic logic [5:0] outs();
        return {gth_reset_all, gth_tx_reset, gth_rx_reset, hssl_enable, link_up, fail};
    endfunction

    always @(negedge clk) begin
        if (rst_n && state !== mon_prev) begin
            if (sb_q.size() == 0) begin
                check_val("sb_unexpected", 32'(sb_q.size()), 32'd1);
            end else begin
                logic [2:0] e;
                e = sb_q.pop_front();
                check_val("sb_state", 32'(state), 32'(e));
                check_val("sb_outputs", 32'(outs()), 32'(exp_outs(e)));
            end
            mon_prev = state;
        end
    end

    task automatic push5();
        sb_q.push_back(3'd1); sb_q.push_back(3'd2); sb_q.push_back(3'd3);
        sb_q.push_back(3'd4); sb_q.push_back(3'd5);
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] tgt, input int budget, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (state !== tgt && cnt < budget);
        if (state !== tgt) check_val("wait_state_budget", 32'(state), 32'(tgt));
    endtask

    task automatic do_start(input string tag);
        int k;
        start = 1'b1;
        wait_state(3'd1, 4, k);
        check_val(tag, k, 1);
        start = 1'b0;
    endtask

    task automatic do_stop();
        sb_q.push_back(3'd0);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; pll_lock = 1'b0;
        tx_reset_done = 1'b0; rx_reset_done = 1'b0; rx_aligned = 1'b0; hssl_handshake = 1'b0;
        tick(3);
        check_val("rst_state", 32'(state), 32'd0);
        check_val("rst_outputs", 32'(outs()), 32'b111000);
        check_val("rst_retry", 32'(retry_cnt), 32'd0);
        check_val("rst_drop", 32'(drop_cnt), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Happy path
        push5();
        do_start("start_latency");
        tick(3);
        pll_lock = 1'b1;
        wait_state(3'd2, 20, n);
        check_val("rst_all_len", 32'(3 + n), 32'd8);
        wait_state(3'd3, 20, n);
        check_val("lock_filter_fast", n, 4);
        tick(4);
        tx_reset_done = 1'b1; rx_reset_done = 1'b1;
        wait_state(3'd4, 4, n);
        check_val("dp_exit_lat", n, 1);
        tick(2);
        rx_aligned = 1'b1; hssl_handshake = 1'b1;
        wait_state(3'd5, 4, n);
        check_val("align_exit_lat", n, 1);
        check_val("up_link", 32'(link_up), 32'd1);
        check_val("up_retry", 32'(retry_cnt), 32'd0);
        check_val("up_resets", 32'({gth_reset_all, gth_tx_reset, gth_rx_reset}), 32'd0);

        // Single-cycle alignment drop in UP
        push5();
        rx_aligned = 1'b0;
        tick(1);
        rx_aligned = 1'b1;
        check_val("drop_link_up", 32'(link_up), 32'd0);
        check_val("drop_state", 32'(state), 32'd1);
        check_val("drop_cnt_1", 32'(drop_cnt), 32'd1);
        check_val("drop_retry", 32'(retry_cnt), 32'd0);
        wait_state(3'd5, 40, n);

        // Drop counter saturation
        force dut.r_drop_cnt = 16'hFFFF;
        tick(1);
        release dut.r_drop_cnt;
        push5();
        rx_aligned = 1'b0;
        tick(1);
        rx_aligned = 1'b1;
        check_val("drop_sat", 32'(drop_cnt), 32'hFFFF);
        wait_state(3'd5, 40, n);

        // Lock glitch: three high, one low, then high
        do_stop();
        pll_lock = 1'b0;
        push5();
        do_start("start_latency_2");
        wait_state(3'd2, 20, n);
        pll_lock = 1'b1;
        tick(3);
        check_val("glitch_hold", 32'(state), 32'd2);
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        wait_state(3'd3, 10, n);
        check_val("glitch_relock", n, 4);
        wait_state(3'd5, 10, n);

        // Stop with simultaneous start edge in IDLE
        do_stop();
        tick(1);
        stop = 1'b1; start = 1'b1;
        tick(1);
        check_val("stop_beats_start", 32'(state), 32'd0);
        stop = 1'b0;
        tick(2);
        check_val("no_edge_after_stop", 32'(state), 32'd0);
        start = 1'b0;
        tick(1);

        // Lock never asserts: retries then FAIL
        pll_lock = 1'b0;
        sb_q.push_back(3'd1); sb_q.push_back(3'd2); sb_q.push_back(3'd1); sb_q.push_back(3'd2);
        sb_q.push_back(3'd1); sb_q.push_back(3'd2); sb_q.push_back(3'd6); sb_q.push_back(3'd1);
        do_start("start_latency_3");
        wait_state(3'd2, 20, n);
        wait_state(3'd1, 80, n);
        check_val("lock_timeout_len", n, 64);
        check_val("retry_1", 32'(retry_cnt), 32'd1);
        wait_state(3'd2, 20, n);
        wait_state(3'd1, 80, n);
        check_val("retry_2", 32'(retry_cnt), 32'd2);
        wait_state(3'd2, 20, n);
        wait_state(3'd6, 80, n);
        check_val("fail_timeout_len", n, 64);
        check_val("fail_flag", 32'(fail), 32'd1);
        check_val("fail_retry", 32'(retry_cnt), 32'd2);
        check_val("fail_resets", 32'({gth_reset_all, gth_tx_reset, gth_rx_reset}), 32'b111);
        tick(3);
        do_start("fail_restart_lat");
        check_val("fail_restart_retry", 32'(retry_cnt), 32'd0);
        do_stop();
        tick(1);

        // Exit condition and timeout coincide in ALIGN
        pll_lock = 1'b1; rx_aligned = 1'b0; hssl_handshake = 1'b0;
        push5();
        do_start("start_latency_4");
        wait_state(3'd4, 40, n);
        tick(63);
        rx_aligned = 1'b1; hssl_handshake = 1'b1;
        wait_state(3'd5, 2, n);
        check_val("align_tie_lat", n, 1);
        check_val("align_tie_retry", 32'(retry_cnt), 32'd0);

        // Asynchronous reset in ALIGN
        do_stop();
        rx_aligned = 1'b0; hssl_handshake = 1'b0;
        sb_q.push_back(3'd1); sb_q.push_back(3'd2); sb_q.push_back(3'd3); sb_q.push_back(3'd4);
        do_start("start_latency_5");
        wait_state(3'd4, 40, n);
        sb_q.push_back(3'd0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_state", 32'(state), 32'd0);
        check_val("arst_outputs", 32'(outs()), 32'b111000);
        check_val("arst_retry", 32'(retry_cnt), 32'd0);
        check_val("arst_drop", 32'(drop_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);

        check_val("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hssl_link_sequencer.md
# hssl_link_sequencer

Bring-up and recovery controller for the GTH transceiver and HSSL link carrying DVS events into the SpiNN-5 board. It sequences the GTH reset domains, waits for PLL lock, datapath reset completion and link alignment, retries on timeout, and reports status on the HSSL virtual I/O probes. It sits between the VIO control probes and the GTH reset inputs. All status inputs arrive already synchronised to `clk`.

## Interface
Parameters:
- RESET_CYCLES, 8: cycles `gth_reset_all` is held in RST_ALL.
- LOCK_FILTER, 4: consecutive cycles `pll_lock` must be high before it is accepted.
- TIMEOUT, 65536: per-state wait limit in cycles for WAIT_LOCK, WAIT_DP and ALIGN.
- MAX_RETRIES, 3: timeouts tolerated before FAIL.

Ports:
- clk  in  1  system clock; the single clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  VIO command; a rising edge starts bring-up.
- stop  in  1  VIO command, level; forces IDLE.
- pll_lock  in  1  GTH PLL locked.
- tx_reset_done  in  1  GTH TX datapath reset complete.
- rx_reset_done  in  1  GTH RX datapath reset complete.
- rx_aligned  in  1  receiver byte/comma aligned.
- hssl_handshake  in  1  HSSL remote handshake complete.
- gth_reset_all  out  1  GTH full reset.
- gth_tx_reset  out  1  TX datapath reset.
- gth_rx_reset  out  1  RX datapath reset.
- hssl_enable  out  1  enables the HSSL frame engine.
- link_up  out  1  link operational.
- fail  out  1  retries exhausted.
- state  out  3  current state encoding, for VIO.
- retry_cnt  out  4  timeouts in the current attempt sequence.
- drop_cnt  out  16  link drops while UP; saturates at 0xFFFF.

## Operation
States and encodings:
- IDLE=0: all three resets=1. A `start` rising edge moves to RST_ALL and clears `retry_cnt`.
- RST_ALL=1: `gth_reset_all`=1, TX/RX resets=1. After RESET_CYCLES cycles, move to WAIT_LOCK.
- WAIT_LOCK=2: `gth_reset_all`=0, TX/RX resets=1. Once `pll_lock` has been high for LOCK_FILTER consecutive cycles, move to WAIT_DP. Any low cycle restarts the filter count.
- WAIT_DP=3: all resets=0. When `tx_reset_done` and `rx_reset_done` are both high, move to ALIGN.
- ALIGN=4: `hssl_enable`=1. When `rx_aligned` and `hssl_handshake` are both high, move to UP.
- UP=5: `hssl_enable`=1, `link_up`=1. If `pll_lock`=0 or `rx_aligned`=0 for any cycle: increment `drop_cnt` (saturating), clear `retry_cnt`, and move to RST_ALL.
- FAIL=6: all resets=1, `fail`=1. Exits only on `stop` (to IDLE) or a `start` rising edge (to RST_ALL, `retry_cnt`=0).

Timeouts:
- A timeout occurs when the state timer reaches TIMEOUT-1 in WAIT_LOCK, WAIT_DP or ALIGN without the exit condition being met.
- On timeout: if `retry_cnt`==MAX_RETRIES, move to FAIL; otherwise increment `retry_cnt` and move to RST_ALL.
- If the exit condition and the timeout occur in the same cycle, the exit condition wins.

Priority and boundary rules:
- `stop` high overrides everything, including a simultaneous `start` edge; the next state is IDLE.
- While `stop` is held, `start` edges are ignored.
- `retry_cnt` is not cleared on reaching UP. It is cleared only on a drop from UP or on a start edge.

Reset values (rst_n low): state IDLE, `gth_reset_all`=1, `gth_tx_reset`=1, `gth_rx_reset`=1, `hssl_enable`=0, `link_up`=0, `fail`=0, `retry_cnt`=0, `drop_cnt`=0, edge-detect register=0, timer=0. Asserting `rst_n` mid-sequence returns all of these immediately (asynchronously).

## Timing
- All outputs are registered and decoded from the next state, so each output changes in the same cycle that `state` shows the new value.
- The `start` edge is detected against a one-cycle-delayed copy: `start`=1 at cycle N with 0 at N-1 gives `state`=RST_ALL at N+1.
- The state timer clears on every state entry. RST_ALL lasts exactly RESET_CYCLES cycles.
- The fastest WAIT_LOCK exit is LOCK_FILTER cycles after entry, with `pll_lock` already high.
- The WAIT_DP and ALIGN exits occur one cycle after their condition is sampled true.
- A drop in UP is seen by `link_up`=0 one cycle later.

## Structure
- Package `hssl_seq_pkg`: the state enum and its encodings, a timer-width constant sized from the largest of TIMEOUT and RESET_CYCLES, and the `drop_cnt` saturation value.
- One sub-module, `hssl_seq_timer`: a clearable up-counter with a terminal-count compare, shared by all states.
- The lock filter is a small counter held in the main FSM.

## Test plan
Benches use RESET_CYCLES=8, LOCK_FILTER=4, TIMEOUT=64, MAX_RETRIES=2.
- Happy path: `start` edge, `pll_lock` high from cycle 10, both reset-done signals high 5 cycles after WAIT_DP entry, align and handshake 3 cycles later -> `state` goes 1,2,3,4,5, `link_up`=1, `retry_cnt`=0, resets 0/0/0.
- Lock never asserts -> three timeouts of 64 cycles (`retry_cnt` 1, then 2) -> FAIL, `fail`=1, all resets=1. A second `start` edge -> RST_ALL with `retry_cnt`=0.
- Lock glitch: `pll_lock` high 3 cycles, low 1 cycle, high -> WAIT_DP entered exactly 4 cycles after re-rise.
- UP then `rx_aligned` low for 1 cycle -> `drop_cnt`=1, `link_up`=0 next cycle, `state`=RST_ALL. Force `drop_cnt` to 0xFFFF -> a further drop keeps it at 0xFFFF.
- Simultaneous events: `stop` together with a `start` edge in IDLE -> stays IDLE. Exit condition and timeout in the same cycle in ALIGN -> UP, `retry_cnt` unchanged.
- `rst_n` pulsed low in ALIGN -> outputs immediately return to their reset values; `state`=0.
